// File: rtl/scalar_mult_ctrl.sv
// Control FSM for scalar point multiplication R = k*Q using MSB-first
// double-and-add; point arithmetic is delegated to a shared unit via op_req/op_ack.
`timescale 1ns/1ps
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module scalar_mult_ctrl #(
  parameter int unsigned DATAWIDTH = `DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] k,
  input  logic [DATAWIDTH-1:0] Qx,
  input  logic [DATAWIDTH-1:0] Qy,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] Rx,
  output logic [DATAWIDTH-1:0] Ry,
  output logic                 inf,
  output logic                 op_req,
  output logic                 op_sel,
  output logic [DATAWIDTH-1:0] op_ax,
  output logic [DATAWIDTH-1:0] op_ay,
  output logic [DATAWIDTH-1:0] op_bx,
  output logic [DATAWIDTH-1:0] op_by,
  input  logic                 op_ack,
  input  logic [DATAWIDTH-1:0] op_rx,
  input  logic [DATAWIDTH-1:0] op_ry,
  input  logic                 op_rinf
);

  localparam int unsigned IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, DONE} state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] k_q, k_d;
  logic [DATAWIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
  logic [DATAWIDTH-1:0] ax_q, ax_d, ay_q, ay_d;
  logic                 ainf_q, ainf_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 busy_d, done_d, inf_d, op_req_d, op_sel_d;
  logic [DATAWIDTH-1:0] rx_d, ry_d;
  logic                 adv;

  // Operands come straight from the accumulator and latched Q, which only
  // change on the ack cycle, so they are stable while op_req is high.
  assign op_ax = ax_q;
  assign op_ay = ay_q;
  assign op_bx = qx_q;
  assign op_by = qy_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    ainf_d  = ainf_q;
    idx_d   = idx_q;
    rx_d    = Rx;
    ry_d    = Ry;
    inf_d   = inf;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          qx_d    = Qx;
          qy_d    = Qy;
          ax_d    = '0;
          ay_d    = '0;
          ainf_d  = 1'b1;
          idx_d   = IW'(DATAWIDTH - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (ainf_q) begin
          if (k_q[idx_q]) begin
            ax_d   = qx_q;
            ay_d   = qy_q;
            ainf_d = 1'b0;
          end
          adv = 1'b1;
        end else begin
          state_d = DBL;
        end
      end
      DBL: begin
        if (op_ack) begin
          ax_d   = op_rinf ? '0 : op_rx;
          ay_d   = op_rinf ? '0 : op_ry;
          ainf_d = op_rinf;
          if (k_q[idx_q]) state_d = ADD;
          else            adv     = 1'b1;
        end
      end
      ADD: begin
        if (op_ack) begin
          ax_d   = op_rinf ? '0 : op_rx;
          ay_d   = op_rinf ? '0 : op_ry;
          ainf_d = op_rinf;
          adv    = 1'b1;
        end
      end
      DONE: begin
        rx_d    = ainf_q ? '0 : ax_q;
        ry_d    = ainf_q ? '0 : ay_q;
        inf_d   = ainf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (idx_q == '0) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = SCAN;
      end
    end

    // Handshake and status flags are registered from the next state.
    busy_d   = (state_d != IDLE);
    op_req_d = (state_d == DBL) || (state_d == ADD);
    op_sel_d = (state_d == ADD);
    done_d   = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      ainf_q  <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Rx      <= '0;
      Ry      <= '0;
      inf     <= 1'b0;
      op_req  <= 1'b0;
      op_sel  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      ainf_q  <= ainf_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      Rx      <= rx_d;
      Ry      <= ry_d;
      inf     <= inf_d;
      op_req  <= op_req_d;
      op_sel  <= op_sel_d;
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Scoreboard bench for scalar_mult_ctrl; the responder models a toy group
// where double(P) = 2P and add(P,Q) = P+Q coordinate-wise mod 256.
`timescale 1ns/1ps

module tb_scalar_mult_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] k = '0, qx = '0, qy = '0;
  logic         busy, done, inf, op_req, op_sel;
  logic [W-1:0] rx, ry, op_ax, op_ay, op_bx, op_by;
  logic         ack_r = 1'b0, stray_ack = 1'b0, op_ack;
  logic [W-1:0] rsp_rx = '0, rsp_ry = '0;
  logic         rsp_inf = 1'b0;

  assign op_ack = ack_r | stray_ack;

  scalar_mult_ctrl #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .Qx(qx), .Qy(qy),
    .busy(busy), .done(done), .Rx(rx), .Ry(ry), .inf(inf),
    .op_req(op_req), .op_sel(op_sel),
    .op_ax(op_ax), .op_ay(op_ay), .op_bx(op_bx), .op_by(op_by),
    .op_ack(op_ack), .op_rx(rsp_rx), .op_ry(rsp_ry), .op_rinf(rsp_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         inf;
    int           lat;
    int           nops;
    logic [15:0]  seq;
    int           st;
  } exp_t;

  exp_t expq[$];
  int   done_cnt = 0;

  // Responder state
  int          dmin = 1, dmax = 1;
  bit          hold_ack = 0;
  bit          inf_first_add = 0;
  int          ops = 0;
  logic [15:0] seq = '0;
  bit          pending = 0;
  bit          unstable = 0;
  int          wcnt = 0;
  logic        cap_sel;
  logic [W-1:0] cap_ax, cap_ay, cap_bx, cap_by;

  always @(negedge clk) begin
    if (rst) begin
      ack_r   = 1'b0;
      pending = 0;
      rsp_inf = 1'b0;
    end else begin
      if (ack_r) begin
        ack_r   = 1'b0;
        pending = 0;
        rsp_inf = 1'b0;
      end
      if (op_req && !pending) begin
        pending  = 1;
        unstable = 0;
        wcnt     = $urandom_range(dmax, dmin);
        cap_sel  = op_sel;
        cap_ax   = op_ax; cap_ay = op_ay; cap_bx = op_bx; cap_by = op_by;
        ops++;
        seq = {seq[14:0], op_sel};
      end
      if (pending) begin
        if (!op_req || op_sel !== cap_sel || op_ax !== cap_ax || op_ay !== cap_ay ||
            (cap_sel && (op_bx !== cap_bx || op_by !== cap_by)))
          unstable = 1;
        if (!hold_ack) begin
          if (wcnt == 0) begin
            check("op_operands_stable", {31'd0, unstable}, 32'd0);
            ack_r = 1'b1;
            if (!cap_sel) begin
              rsp_rx = cap_ax + cap_ax;
              rsp_ry = cap_ay + cap_ay;
              rsp_inf = 1'b0;
            end else begin
              rsp_rx = cap_ax + cap_bx;
              rsp_ry = cap_ay + cap_by;
              rsp_inf = inf_first_add;
              inf_first_add = 0;
            end
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("Rx", {24'd0, rx}, {24'd0, e.rx});
        check("Ry", {24'd0, ry}, {24'd0, e.ry});
        check("inf", {31'd0, inf}, {31'd0, e.inf});
        if (e.lat >= 0) check("latency", cyc - e.st, e.lat);
        check("op_count", ops, e.nops);
        check("op_sel_seq", {16'd0, seq}, {16'd0, e.seq});
      end
    end
  end

  task automatic run(input logic [W-1:0] kk, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] erx, input logic [W-1:0] ery, input logic einf,
                     input int lat, input int nops, input logic [15:0] eseq,
                     input int lo, input int hi, input bit inject);
    exp_t e;
    int   target;
    dmin = lo; dmax = hi;
    ops = 0; seq = '0;
    @(negedge clk);
    start = 1'b1; k = kk; qx = x; qy = y;
    @(posedge clk); #1;
    start = 1'b0;
    e.rx = erx; e.ry = ery; e.inf = einf; e.lat = lat; e.nops = nops; e.seq = eseq; e.st = cyc;
    expq.push_back(e);
    target = done_cnt + 1;
    for (int c = 0; c < 2000 && done_cnt < target; c++) begin
      @(posedge clk); #1;
      if (inject && c == 3) begin
        check("busy_at_ignored_start", {31'd0, busy}, 32'd1);
        start = 1'b1; k = 8'hFF; qx = 8'h09; qy = 8'h0B;
      end
      if (inject && c == 4) start = 1'b0;
    end
    if (done_cnt < target) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done, expected done for k=%0h", kk);
      void'(expq.pop_front());
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_op_req", {31'd0, op_req}, 32'd0);
    check("rst_op_sel", {31'd0, op_sel}, 32'd0);
    check("rst_inf", {31'd0, inf}, 32'd0);
    check("rst_RxRy", {16'd0, rx, ry}, 32'd0);
    check("rst_op_a", {16'd0, op_ax, op_ay}, 32'd0);
    rst = 1'b0;

    //  k      Qx     Qy     Rx     Ry     inf  lat nops seq       dmin dmax inj
    run(8'd0,  8'd5,  8'd1,  8'd0,  8'd0,  1'b1, 9,  0,  16'h0000, 1, 1, 0);
    run(8'd1,  8'd5,  8'd1,  8'd5,  8'd1,  1'b0, 9,  0,  16'h0000, 1, 1, 0);
    run(8'd6,  8'd7,  8'd3,  8'd42, 8'd18, 1'b0, 15, 3,  16'h0002, 1, 1, 0);
    run(8'd255,8'd3,  8'd5,  8'd253,8'd251,1'b0, -1, 14, 16'h1555, 1, 5, 0);
    inf_first_add = 1;
    run(8'd3,  8'd7,  8'd3,  8'd0,  8'd0,  1'b1, 13, 2,  16'h0001, 1, 1, 1);

    // Abort an operation mid-flight with the ack withheld.
    hold_ack = 1; ops = 0; seq = '0;
    @(negedge clk);
    start = 1'b1; k = 8'd6; qx = 8'd7; qy = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !op_req; c++) begin
      @(posedge clk); #1;
    end
    check("op_req_before_rst", {31'd0, op_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_op_req", {31'd0, op_req}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_ack = 0;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ack_op_req", {31'd0, op_req}, 32'd0);
    check("stray_ack_busy", {31'd0, busy}, 32'd0);

    run(8'd2,  8'd7,  8'd3,  8'd14, 8'd6,  1'b0, 11, 1,  16'h0000, 1, 1, 0);

    repeat (4) @(posedge clk);
    check("queue_empty", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
